// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial program loader.
// Holds the core in reset until a clean load completes.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   load_start        pulse: begin or restart a load
//   load_valid/byte   program image byte stream
//   load_last         marks the final byte of the image
//   load_ready        byte accepted when valid & ready
//   instr_addr        core byte fetch address
//   instr_in          fetched word (0 = nop when unavailable)
//   cpu_reset         core reset, 1 = held
//   load_done         1 while running
//   load_error        1 after an overflowing load
//   loaded_words      words written by current/last load
module instr_mem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [7:0]                     load_byte,
    input  logic                           load_last,
    output logic                           load_ready,
    input  logic [31:0]                    instr_addr,
    output logic [31:0]                    instr_in,
    output logic                           cpu_reset,
    output logic                           load_done,
    output logic                           load_error,
    output logic [$clog2(DEPTH_WORDS):0]   loaded_words
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH_WORDS);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [AW:0] word_ptr;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_word;
    logic        ovf;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        ptr_full;
    logic        ovf_hit;
    logic        word_wr;
    logic [1:0]  lane;
    logic [31:0] merged;
    logic [31:0] offset;
    logic        in_range;

    assign load_ready = (state == S_LOAD);

    // A byte coinciding with load_start belongs to the aborted load.
    assign accept   = load_valid & load_ready & ~load_start;
    assign ptr_full = (word_ptr == PTR_FULL);
    assign ovf_hit  = accept & ptr_full;

    assign lane   = BIG_ENDIAN ? (2'd3 - byte_cnt) : byte_cnt;
    assign merged = asm_word | ({24'd0, load_byte} << {lane, 3'b000});

    // Flush on the 4th byte, or early on load_last (unfilled lanes stay 0).
    assign word_wr = accept & ~ptr_full & ((byte_cnt == 2'd3) | load_last);

    assign loaded_words = word_ptr;

    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = S_LOAD;
        end else if (accept && load_last) begin
            state_next = (ovf || ovf_hit) ? S_ERROR : S_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_ptr   <= '0;
            byte_cnt   <= 2'd0;
            asm_word   <= 32'd0;
            ovf        <= 1'b0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            cpu_reset  <= (state_next != S_RUN);
            load_done  <= (state_next == S_RUN);
            load_error <= (state_next == S_ERROR);
            if (load_start) begin
                word_ptr <= '0;
                byte_cnt <= 2'd0;
                asm_word <= 32'd0;
                ovf      <= 1'b0;
            end else if (accept) begin
                if (ptr_full) begin
                    ovf <= 1'b1;
                end else if (word_wr) begin
                    word_ptr <= word_ptr + PTR_ONE;
                    byte_cnt <= 2'd0;
                    asm_word <= 32'd0;
                end else begin
                    asm_word <= merged;
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[word_ptr[AW-1:0]] <= merged;
        end
    end

    // Fetch: asynchronous read, gated to RUN and aligned in-range words.
    assign offset   = instr_addr - BASE_ADDR;
    assign in_range = (offset[31:AW+2] == '0);

    always_comb begin
        instr_in = 32'h0000_0000;
        if (state == S_RUN && offset[1:0] == 2'b00 && in_range) begin
            instr_in = mem[offset[AW+1:2]];
        end
    end

endmodule
